prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Byte-stream program loader: initiator on the memory write/read port (drives write, t_reg, write_val; reads t_val).
//  Receives a framed image over a valid/ready byte channel and assembles 16-bit words.
//  Writes each word to consecutive addresses and read-back verifies it, then checks a trailing checksum.
//  Holds the core while loading; sits between the host/UART byte source and memory.
// PARAMETERS
//  BASE_ADDR  16'h0000  address of first data word
//  TIMEOUT    1000000   max idle cycles between accepted bytes while loading; 0 disables timeout
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   begin a load (honoured only in IDLE/DONE/ERROR)
//  byte_valid in   1   byte_data valid
//  byte_data  in   8   stream byte
//  byte_ready out  1   loader accepts byte this cycle
//  mem_write  out  1   memory write strobe (to write)
//  mem_addr   out  16  memory address (to t_reg)
//  mem_wdata  out  16  memory write data (to write_val)
//  mem_rdata  in   16  combinational read at mem_addr (from t_val)
//  core_hold  out  1   high while busy; core must stall
//  done       out  1   load completed OK (sticky)
//  err        out  2   00 none, 01 verify mismatch, 10 checksum mismatch, 11 timeout (sticky)
// BEHAVIOUR
//  Frame (high byte first everywhere): LEN_HI LEN_LO, then LEN words (HI,LO), then SUM_HI SUM_LO.
//  SUM = mod-2^16 sum of all data words (LEN not included).
//  Byte accepted iff byte_valid && byte_ready on a clk edge.
//  Reset: state IDLE; all outputs 0; mem_addr=BASE_ADDR; internal count/sum/timer cleared.
//  States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, VERIFY, SUM_HI, SUM_LO, DONE, ERROR.
//  - IDLE/DONE/ERROR + start: clear done/err/sum/timer, mem_addr<=BASE_ADDR, -> LEN_HI.
//  - byte_ready=1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO, SUM_HI, SUM_LO.
//  - LEN_LO accept: LEN==0 -> SUM_HI, else -> DAT_HI.
//  - DAT_LO accept: word latched into mem_wdata -> WRITE.
//  - WRITE: mem_write=1 for exactly one cycle, mem_addr/mem_wdata stable -> VERIFY.
//  - VERIFY: mem_write=0, compare mem_rdata to mem_wdata. Mismatch -> ERROR, err=01.
//    Match: sum+=word, count-=1, mem_addr+=1 (wraps 16'hFFFF->0); count==0 -> SUM_HI else DAT_HI.
//  - SUM_LO accept: match -> DONE, done=1; else -> ERROR, err=10.
//  - Per-word latency: last byte accept -> write strobe next cycle -> verify cycle after; 2 cycles min/word.
//  - core_hold=1 in every state except IDLE, DONE, ERROR.
//  - Timer: reset on each accepted byte and on entry to LEN_HI; counts in byte-wait states while
//    byte_ready && !byte_valid; reaching TIMEOUT -> ERROR, err=11. Not counted in WRITE/VERIFY.
//  - start while busy: ignored. start and rst same cycle: rst wins.
//  - rst mid-load: immediate IDLE, outputs 0; already-written memory words are not undone.
//  - done and err never both nonzero; both held until start or rst.
//  - mem_write is never asserted outside WRITE.
// TESTING
//  1 rst, start, bytes 00 02 12 34 AB CD BE 01 -> mem[0]=1234, mem[1]=ABCD, 2 write strobes, done=1, err=00.
//  2 LEN=0: bytes 00 00 00 00 -> no mem_write, done=1; with 00 00 00 01 -> err=10, done=0.
//  3 BASE_ADDR=16'hFFFF, 2 words 0001 0002 -> writes at FFFF then 0000, sum 0003 -> done=1.
//  4 memory model forces read-back of word 0 to 0000 (written 1234) -> err=01, state ERROR after VERIFY, no further writes.
//  5 TIMEOUT=10, stall byte_valid low for 10 cycles after LEN_HI -> err=11, core_hold=0; start restarts cleanly.
//  6 rst asserted during DAT_LO with start high -> next cycle all outputs 0, IDLE; new full load then succeeds.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames LEN, LEN data words and a checksum, writing and read-back verifying each word.
// Each word needs 2 cycles after its last byte (write, then verify); byte_ready is low during those cycles and outside a load.
module prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        core_hold,
  output logic        done,
  output logic [1:0]  err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_WRITE,
    S_VERIFY, S_SUM_HI, S_SUM_LO, S_DONE, S_ERROR
  } state_t;

  state_t      state, state_nx;
  logic [15:0] addr_nx, wdata_nx, count, count_nx, sum, sum_nx;
  logic [7:0]  hi_byte, hi_nx;
  logic [31:0] timer, timer_nx;
  logic        done_nx;
  logic [1:0]  err_nx;
  logic        accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      hi_byte   <= '0;
      count     <= '0;
      sum       <= '0;
      timer     <= '0;
      done      <= 1'b0;
      err       <= 2'b00;
    end else begin
      state     <= state_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      hi_byte   <= hi_nx;
      count     <= count_nx;
      sum       <= sum_nx;
      timer     <= timer_nx;
      done      <= done_nx;
      err       <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    addr_nx    = mem_addr;
    wdata_nx   = mem_wdata;
    hi_nx      = hi_byte;
    count_nx   = count;
    sum_nx     = sum;
    timer_nx   = timer;
    done_nx    = done;
    err_nx     = err;
    byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DAT_HI) ||
                 (state == S_DAT_LO) || (state == S_SUM_HI) || (state == S_SUM_LO);
    mem_write  = (state == S_WRITE);
    core_hold  = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    accept     = byte_valid && byte_ready;

    // Idle-gap watchdog; the case below only moves state on an accepted byte, so no conflict.
    if (byte_ready) begin
      if (accept) begin
        timer_nx = '0;
      end else if ((TIMEOUT != 0) && (timer >= TIMEOUT - 32'd1)) begin
        state_nx = S_ERROR;
        err_nx   = 2'b11;
      end else begin
        timer_nx = timer + 32'd1;
      end
    end

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          done_nx  = 1'b0;
          err_nx   = 2'b00;
          sum_nx   = '0;
          timer_nx = '0;
          addr_nx  = BASE_ADDR;
          state_nx = S_LEN_HI;
        end
      end
      S_LEN_HI: if (accept) begin
        hi_nx    = byte_data;
        state_nx = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        count_nx = {hi_byte, byte_data};
        state_nx = ({hi_byte, byte_data} == 16'h0000) ? S_SUM_HI : S_DAT_HI;
      end
      S_DAT_HI: if (accept) begin
        hi_nx    = byte_data;
        state_nx = S_DAT_LO;
      end
      S_DAT_LO: if (accept) begin
        wdata_nx = {hi_byte, byte_data};
        state_nx = S_WRITE;
      end
      S_WRITE: state_nx = S_VERIFY;
      S_VERIFY: begin
        if (mem_rdata != mem_wdata) begin
          err_nx   = 2'b01;
          state_nx = S_ERROR;
        end else begin
          sum_nx   = sum + mem_wdata;
          count_nx = count - 16'd1;
          addr_nx  = mem_addr + 16'd1;
          state_nx = (count == 16'd1) ? S_SUM_HI : S_DAT_HI;
        end
      end
      S_SUM_HI: if (accept) begin
        hi_nx    = byte_data;
        state_nx = S_SUM_LO;
      end
      S_SUM_LO: if (accept) begin
        if ({hi_byte, byte_data} == sum) begin
          done_nx  = 1'b1;
          state_nx = S_DONE;
        end else begin
          err_nx   = 2'b10;
          state_nx = S_ERROR;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0000 and FFFF, short timeout) fed the same byte stream,
// each with its own memory model and write scoreboard.
module tb_prog_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, byte_valid = 1'b0, corrupt = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        br0, mw0, ch0, dn0, br1, mw1, ch1, dn1;
  logic [15:0] a0, wd0, rd0, a1, wd1, rd1;
  logic [1:0]  er0, er1;
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem1 [0:65535];

  prog_loader #(.BASE_ADDR(16'h0000), .TIMEOUT(10)) u0 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(br0), .mem_write(mw0), .mem_addr(a0), .mem_wdata(wd0), .mem_rdata(rd0),
    .core_hold(ch0), .done(dn0), .err(er0));
  prog_loader #(.BASE_ADDR(16'hFFFF), .TIMEOUT(10)) u1 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(br1), .mem_write(mw1), .mem_addr(a1), .mem_wdata(wd1), .mem_rdata(rd1),
    .core_hold(ch1), .done(dn1), .err(er1));

  assign rd0 = (corrupt && a0 == 16'h0000) ? 16'h0000 : mem0[a0];
  assign rd1 = mem1[a1];
  always @(posedge clk) begin
    if (mw0) mem0[a0] <= wd0;
    if (mw1) mem1[a1] <= wd1;
  end

  int checks = 0, errors = 0;
  int wc0 = 0, wc1 = 0;
  logic [31:0] sb0[$], sb1[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Write monitor: every strobe cycle must match the next expected {addr,data}.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (mw0) begin
      wc0++;
      if (sb0.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr0_unexpected: got %h, expected no write", {a0, wd0});
      end else begin
        e = sb0.pop_front();
        chk("wr0", {a0, wd0}, e);
      end
    end
    if (mw1) begin
      wc1++;
      if (sb1.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr1_unexpected: got %h, expected no write", {a1, wd1});
      end else begin
        e = sb1.pop_front();
        chk("wr1", {a1, wd1}, e);
      end
    end
  end

  typedef struct {
    int          n;
    logic [95:0] b;
    logic        dn;
    logic [1:0]  er;
  } vec_t;
  vec_t vt[6];

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0; byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk); byte_valid = 1'b1; byte_data = b;
    for (int k = 0; k < 20; k++) begin
      if (br0) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Sends n bytes from a left-aligned image and queues the writes each data word must cause.
  task automatic send_frame(input int n, input logic [95:0] bytes, output bit ok);
    logic [7:0]  cur, prev;
    logic [15:0] len;
    bit          k;
    int          w;
    ok = 1'b1;
    prev = 8'h00;
    len = bytes[95:80];
    for (int i = 0; i < n; i++) begin
      cur = bytes[95-8*i -: 8];
      send_byte(cur, k);
      if (!k) begin
        ok = 1'b0;
        return;
      end
      if (i >= 3 && i < 2 + 2 * len && (i % 2) == 1) begin
        w = (i - 3) / 2;
        sb0.push_back({16'h0000 + 16'(w), prev, cur});
        sb1.push_back({16'hFFFF + 16'(w), prev, cur});
      end
      prev = cur;
    end
  endtask

  task automatic wait_idle(input string nm);
    @(negedge clk); byte_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (!ch0) break;
      @(negedge clk);
    end
    chk({nm, "_idle"}, ch0, 1'b0);
  endtask

  initial begin
    bit ok;
    vt[0] = '{8,  {64'h0002_1234_ABCD_BE01, 32'h0},     1'b1, 2'b00};
    vt[1] = '{4,  {32'h0000_0000, 64'h0},              1'b1, 2'b00};
    vt[2] = '{4,  {32'h0000_0001, 64'h0},              1'b0, 2'b10};
    vt[3] = '{10, {80'h0003_FFFF_0001_0005_0005, 16'h0}, 1'b1, 2'b00};
    vt[4] = '{6,  {48'h0001_55AA_55AB, 48'h0},         1'b0, 2'b10};
    vt[5] = '{8,  {64'h0002_0001_0002_0003, 32'h0},     1'b1, 2'b00};

    do_reset();
    @(negedge clk);
    chk("rst_outs0", {br0, mw0, ch0, dn0, er0}, 6'b0);
    chk("rst_addr0", a0, 16'h0000);
    chk("rst_wdata0", wd0, 16'h0000);
    chk("rst_addr1", a1, 16'hFFFF);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      wc0 = 0; wc1 = 0;
      start_load();
      send_frame(vt[i].n, vt[i].b, ok);
      chk($sformatf("v%0d_sent", i), ok, 1'b1);
      wait_idle($sformatf("v%0d", i));
      chk($sformatf("v%0d_done0", i), dn0, vt[i].dn);
      chk($sformatf("v%0d_err0", i), er0, vt[i].er);
      chk($sformatf("v%0d_done1", i), dn1, vt[i].dn);
      chk($sformatf("v%0d_err1", i), er1, vt[i].er);
      chk($sformatf("v%0d_nwr0", i), wc0, vt[i].b[95:80]);
      chk($sformatf("v%0d_nwr1", i), wc1, vt[i].b[95:80]);
      chk($sformatf("v%0d_sbq", i), sb0.size() + sb1.size(), 0);
    end

    // Read-back corruption of word 0: error after its verify, no further writes.
    do_reset();
    wc0 = 0; corrupt = 1'b1;
    start_load();
    send_frame(4, {32'h0002_1234, 64'h0}, ok);
    chk("vfy_sent", ok, 1'b1);
    @(negedge clk); byte_valid = 1'b0;
    chk("vfy_wstrobe", mw0, 1'b1);
    @(negedge clk);
    chk("vfy_cycle", {mw0, ch0, er0}, {1'b0, 1'b1, 2'b00});
    @(negedge clk);
    chk("vfy_err", {dn0, er0}, {1'b0, 2'b01});
    chk("vfy_hold", ch0, 1'b0);
    repeat (15) @(negedge clk);
    chk("vfy_nwr", wc0, 1);
    chk("vfy_sbq", sb0.size(), 0);
    corrupt = 1'b0;

    // Stall after LEN_HI: nine idle cycles stay busy, the tenth times out.
    do_reset();
    start_load();
    send_byte(8'h00, ok);
    chk("to_sent", ok, 1'b1);
    @(negedge clk); byte_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("to_busy", {ch0, er0}, {1'b1, 2'b00});
    @(posedge clk);
    @(negedge clk);
    chk("to_err", {ch0, dn0, er0}, {1'b0, 1'b0, 2'b11});
    // Restart from ERROR without reset.
    wc0 = 0;
    start_load();
    chk("to_restart_clr", {dn0, er0, ch0}, {1'b0, 2'b00, 1'b1});
    send_frame(vt[0].n, vt[0].b, ok);
    chk("to_restart_sent", ok, 1'b1);
    wait_idle("to_restart");
    chk("to_restart_res", {dn0, er0}, {1'b1, 2'b00});
    chk("to_restart_nwr", wc0, 2);
    chk("mem0_0", mem0[16'h0000], 16'h1234);
    chk("mem0_1", mem0[16'h0001], 16'hABCD);
    chk("mem1_ffff", mem1[16'hFFFF], 16'h1234);
    chk("mem1_0", mem1[16'h0000], 16'hABCD);

    // Reset with start high while waiting in DAT_LO: reset wins.
    do_reset();
    start_load();
    send_frame(3, {24'h000212, 72'h0}, ok);
    chk("rs_sent", ok, 1'b1);
    @(negedge clk); rst = 1'b1; start = 1'b1; byte_valid = 1'b0;
    @(negedge clk);
    chk("rs_outs", {br0, mw0, ch0, dn0, er0}, 6'b0);
    chk("rs_addr_wdata", {a0, wd0}, {16'h0000, 16'h0000});
    rst = 1'b0; start = 1'b0;
    wc0 = 0;
    start_load();
    send_frame(vt[0].n, vt[0].b, ok);
    chk("rs_reload_sent", ok, 1'b1);
    wait_idle("rs_reload");
    chk("rs_reload_res", {dn0, er0}, {1'b1, 2'b00});
    chk("rs_reload_nwr", wc0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
